// File: rtl/garota_viol_ctrl_pkg.sv
// rtl/garota_viol_ctrl_pkg.sv - state type and sizing helpers for the violation controller
`include "garota_viol_defines.v"

package garota_viol_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = `GAROTA_VIOL_ST_IDLE,
        ST_HOLD      = `GAROTA_VIOL_ST_HOLD,
        ST_WAIT_HDLR = `GAROTA_VIOL_ST_WAIT_HDLR
    } viol_state_e;

    localparam logic [15:0] HOLD_MIN = `GAROTA_VIOL_HOLD_MIN;

    // Hold counter preload: the pulse lasts preload+1 cycles, never shorter than HOLD_MIN
    function automatic logic [15:0] hold_load(input logic [15:0] cycles);
        return ((cycles < HOLD_MIN) ? HOLD_MIN : cycles) - 16'd1;
    endfunction

    // Width of a source index; a single source still needs one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/garota_viol_ctrl_if.sv
// rtl/garota_viol_ctrl_if.sv - monitor/core-side signal bundle of the violation controller
interface garota_viol_ctrl_if
    import garota_viol_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 8
);
    localparam int ID_W = id_width(NUM_SRC);

    logic [15:0]        pc;
    logic [NUM_SRC-1:0] viol_req;
    logic               log_clr;
    logic               core_rst;
    logic               busy;
    logic [NUM_SRC-1:0] cause_vec;
    logic [ID_W-1:0]    cause_id;
    logic [15:0]        cause_pc;
    logic [CNT_W-1:0]   viol_cnt;

    modport master (
        output pc, viol_req, log_clr,
        input  core_rst, busy, cause_vec, cause_id, cause_pc, viol_cnt
    );

    modport slave (
        input  pc, viol_req, log_clr,
        output core_rst, busy, cause_vec, cause_id, cause_pc, viol_cnt
    );
endinterface

// File: rtl/garota_viol_defines.v
// rtl/garota_viol_defines.v - shared state encodings and hold-length clamp for the violation controller
`ifndef GAROTA_VIOL_DEFINES_V
`define GAROTA_VIOL_DEFINES_V

`define GAROTA_VIOL_ST_IDLE      2'd0
`define GAROTA_VIOL_ST_HOLD      2'd1
`define GAROTA_VIOL_ST_WAIT_HDLR 2'd2

// Shortest core reset pulse; a configured hold length below this is raised to it
`define GAROTA_VIOL_HOLD_MIN     16'd1

`endif

// File: rtl/garota_viol_prio_enc.sv
// rtl/garota_viol_prio_enc.sv - combinational lowest-index priority encoder
module garota_viol_prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [ID_W-1:0]    id
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/garota_viol_ctrl.sv
// rtl/garota_viol_ctrl.sv - violation controller top; optional cause_pc/viol_cnt logging via GAROTA_VIOL_LOG_EN
module garota_viol_ctrl
    import garota_viol_ctrl_pkg::*;
#(
    parameter int          NUM_SRC       = 4,
    parameter logic [15:0] HOLD_CYCLES   = 16'd8,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int          CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    garota_viol_ctrl_if.slave bus
);

    localparam int          ID_W      = id_width(NUM_SRC);
    localparam logic [15:0] HOLD_LOAD = hold_load(HOLD_CYCLES);

    viol_state_e        state;
    logic [15:0]        hold_cnt;
    logic               core_rst_q;
    logic               busy_q;
    logic [NUM_SRC-1:0] cause_vec_q;
    logic [ID_W-1:0]    cause_id_q;
    logic [ID_W-1:0]    prio_id;
    logic               accept;

    garota_viol_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req (bus.viol_req),
        .id  (prio_id)
    );

    // Requests are only honoured outside the reset pulse
    assign accept = (|bus.viol_req) && ((state == ST_IDLE) || (state == ST_WAIT_HDLR));

    // Sequencer: accept -> fixed-length core reset -> wait for the handler PC
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            core_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            cause_vec_q <= '0;
            cause_id_q  <= '0;
        end else begin
            if (accept) begin
                cause_vec_q <= bus.viol_req;
                cause_id_q  <= prio_id;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_HOLD;
                        hold_cnt   <= HOLD_LOAD;
                        core_rst_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == 16'd0) begin
                        state      <= ST_WAIT_HDLR;
                        core_rst_q <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end
                end
                ST_WAIT_HDLR: begin
                    // A fresh violation outranks the handler re-entry
                    if (accept) begin
                        state      <= ST_HOLD;
                        hold_cnt   <= HOLD_LOAD;
                        core_rst_q <= 1'b1;
                    end else if (bus.pc == RESET_HANDLER) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    core_rst_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_rst  = core_rst_q;
    assign bus.busy      = busy_q;
    assign bus.cause_vec = cause_vec_q;
    assign bus.cause_id  = cause_id_q;

`ifdef GAROTA_VIOL_LOG_EN
    logic [15:0]      cause_pc_q;
    logic [CNT_W-1:0] viol_cnt_q;

    // Violation log: faulting PC and a saturating count; a clear on an accept leaves one
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_pc_q <= '0;
            viol_cnt_q <= '0;
        end else begin
            if (accept) begin
                cause_pc_q <= bus.pc;
            end
            if (bus.log_clr) begin
                viol_cnt_q <= accept ? CNT_W'(1) : '0;
            end else if (accept && (viol_cnt_q != {CNT_W{1'b1}})) begin
                viol_cnt_q <= viol_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.cause_pc = cause_pc_q;
    assign bus.viol_cnt = viol_cnt_q;
`else
    logic unused_log_clr;
    assign unused_log_clr = bus.log_clr;
    assign bus.cause_pc   = '0;
    assign bus.viol_cnt   = '0;
`endif

endmodule

// File: tb/tb_garota_viol_ctrl.sv
// tb/tb_garota_viol_ctrl.sv - scoreboard bench for garota_viol_ctrl
module tb_garota_viol_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    garota_viol_ctrl_if #(.NUM_SRC(4), .CNT_W(8)) bus_a();
    garota_viol_ctrl_if #(.NUM_SRC(4), .CNT_W(2)) bus_b();

    garota_viol_ctrl #(
        .NUM_SRC(4), .HOLD_CYCLES(16'd8), .RESET_HANDLER(16'h0000), .CNT_W(8)
    ) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    garota_viol_ctrl #(
        .NUM_SRC(4), .HOLD_CYCLES(16'd0), .RESET_HANDLER(16'h0000), .CNT_W(2)
    ) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

    typedef struct {
        int          len;
        logic [3:0]  vec;
        logic [1:0]  id;
        logic [15:0] pc;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   len_a  = 0;
    int   cnt_a  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = i[1:0];
        end
        return r;
    endfunction

    function automatic logic [15:0] lg16(input logic [15:0] v);
`ifdef GAROTA_VIOL_LOG_EN
        return v;
`else
        return (v & 16'h0000);
`endif
    endfunction

    function automatic logic [7:0] lg8(input logic [7:0] v);
`ifdef GAROTA_VIOL_LOG_EN
        return v;
`else
        return (v & 8'h00);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int len, input logic [3:0] vec, input logic [15:0] pc, input int cnt);
        exp_t e;
        e.len = len;
        e.vec = vec;
        e.id  = low_idx(vec);
        e.pc  = lg16(pc);
        e.cnt = lg8(8'(cnt));
        sb_q.push_back(e);
    endtask

    task automatic wait_fall_a();
        for (int i = 0; i < 40 && bus_a.core_rst; i++) tick();
        check("core_rst_fall_timeout", 32'(bus_a.core_rst), 32'd0);
    endtask

    task automatic violate_a(input logic [3:0] vec, input logic [15:0] pc);
        cnt_a++;
        bus_a.pc       = pc;
        bus_a.viol_req = vec;
        push(8, vec, pc, cnt_a);
        tick();
        bus_a.viol_req = 4'b0000;
    endtask

    // Measure each core_rst pulse of DUT A and compare against the queued expectation
    always @(negedge clk) begin
        if (bus_a.core_rst === 1'b1) begin
            len_a++;
        end else if (len_a != 0) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_len", 32'(len_a), 32'(mon_e.len));
                check("cause_vec", 32'(bus_a.cause_vec), 32'(mon_e.vec));
                check("cause_id",  32'(bus_a.cause_id),  32'(mon_e.id));
                check("cause_pc",  32'(bus_a.cause_pc),  32'(mon_e.pc));
                check("viol_cnt",  32'(bus_a.viol_cnt),  32'(mon_e.cnt));
            end
            len_a = 0;
        end
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.pc = 16'h1234; bus_a.viol_req = 4'b0; bus_a.log_clr = 1'b0;
        bus_b.pc = 16'hE000; bus_b.viol_req = 4'b0; bus_b.log_clr = 1'b0;

        // Reset state
        tick(); tick();
        rst_a = 1'b0;
        tick();
        check("rst_core_rst",  32'(bus_a.core_rst),  32'd0);
        check("rst_busy",      32'(bus_a.busy),      32'd0);
        check("rst_cause_vec", 32'(bus_a.cause_vec), 32'd0);
        check("rst_cause_id",  32'(bus_a.cause_id),  32'd0);
        check("rst_cause_pc",  32'(bus_a.cause_pc),  32'd0);
        check("rst_viol_cnt",  32'(bus_a.viol_cnt),  32'd0);

        // Single violation, with a request mid-HOLD that must be ignored
        violate_a(4'b0100, 16'hE010);
        check("accept_core_rst", 32'(bus_a.core_rst), 32'd1);
        check("accept_busy",     32'(bus_a.busy),     32'd1);
        tick(); tick(); tick();
        bus_a.viol_req = 4'b0001;
        tick();
        bus_a.viol_req = 4'b0000;
        wait_fall_a();
        check("wait_busy", 32'(bus_a.busy), 32'd1);
        tick(); tick();
        check("wait_busy_hold", 32'(bus_a.busy), 32'd1);
        bus_a.pc = 16'h0000;
        tick();
        check("hdlr_busy_low", 32'(bus_a.busy), 32'd0);
        check("hdlr_core_rst", 32'(bus_a.core_rst), 32'd0);

        // Simultaneous requests, then a repeat violation while waiting for the handler
        violate_a(4'b1010, 16'hE100);
        wait_fall_a();
        violate_a(4'b1000, 16'hE200);
        check("reentry_core_rst", 32'(bus_a.core_rst), 32'd1);
        wait_fall_a();

        // Violation coinciding with the handler PC wins
        violate_a(4'b0010, 16'h0000);
        check("prio_core_rst", 32'(bus_a.core_rst), 32'd1);
        wait_fall_a();
        tick();
        check("prio_idle_busy", 32'(bus_a.busy), 32'd0);

        // Counter clear leaves state and cause untouched
        bus_a.log_clr = 1'b1;
        tick();
        bus_a.log_clr = 1'b0;
        cnt_a = 0;
        check("clr_viol_cnt",  32'(bus_a.viol_cnt),  32'd0);
        check("clr_busy",      32'(bus_a.busy),      32'd0);
        check("clr_cause_vec", 32'(bus_a.cause_vec), 32'h2);

        // Reset three cycles into HOLD truncates the pulse and clears the log
        bus_a.pc = 16'hE300;
        bus_a.viol_req = 4'b0001;
        push(3, 4'b0000, 16'h0000, 0);
        tick();
        bus_a.viol_req = 4'b0000;
        tick(); tick();
        rst_a = 1'b1;
        tick();
        check("midrst_core_rst", 32'(bus_a.core_rst), 32'd0);
        check("midrst_viol_cnt", 32'(bus_a.viol_cnt), 32'd0);
        check("midrst_busy",     32'(bus_a.busy),     32'd0);
        rst_a = 1'b0;
        cnt_a = 0;
        tick();
        bus_a.pc = 16'hE400;
        violate_a(4'b0100, 16'hE400);
        wait_fall_a();

        // DUT B: HOLD_CYCLES=0 gives a one-cycle pulse; 2-bit counter saturates
        rst_b = 1'b0;
        tick();
        check("b_rst_cnt", 32'(bus_b.viol_cnt), 32'd0);
        bus_b.viol_req = 4'b0100;
        tick();
        bus_b.viol_req = 4'b0000;
        check("b_h0_rst_high", 32'(bus_b.core_rst), 32'd1);
        tick();
        check("b_h0_rst_low", 32'(bus_b.core_rst), 32'd0);
        check("b_h0_busy",    32'(bus_b.busy),     32'd1);
        check("b_cnt1",       32'(bus_b.viol_cnt), 32'(lg8(8'd1)));
        bus_b.viol_req = 4'b0001;
        for (int i = 0; i < 8; i++) tick();
        bus_b.viol_req = 4'b0000;
        check("b_sat_cnt",     32'(bus_b.viol_cnt), 32'(lg8(8'd3)));
        check("b_sat_core_rst", 32'(bus_b.core_rst), 32'd0);
        bus_b.viol_req = 4'b0010;
        bus_b.log_clr  = 1'b1;
        tick();
        bus_b.viol_req = 4'b0000;
        bus_b.log_clr  = 1'b0;
        check("b_clr_accept_cnt", 32'(bus_b.viol_cnt), 32'(lg8(8'd1)));
        check("b_clr_core_rst",   32'(bus_b.core_rst), 32'd1);
        check("b_clr_cause_id",   32'(bus_b.cause_id), 32'd1);
        check("b_cause_pc",       32'(bus_b.cause_pc), 32'(lg16(16'hE000)));

        tick(); tick();
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
